vga_scan_ctrl: RTL and testbench

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_scan_ctrl.sv | 110 +++++++++++
 tb/tb_vga_scan_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA scan timing generator.
// Free-running horizontal/vertical counters produce the scan position (x/y)
// for the upstream colour pipeline. Sync and blanking are delayed two clocks
// so they line up with the returned colour and this block's output register.
module vga_scan_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] color_in,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       visible;
  logic       hs_raw;
  logic       vs_raw;

  // Pipeline stage 1: aligned with color_in arriving from the upstream register.
  logic       hs_d1;
  logic       vs_d1;
  logic       vis_d1;

  // Scan counters; the vertical counter advances only when the line wraps,
  // so both wrap together at the last pixel of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      if (v_cnt == V_MAX) v_cnt <= '0;
      else                v_cnt <= v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Undelayed decode of the current scan position.
  always_comb begin
    visible = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs_raw  = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs_raw  = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
  end

  // Scan position to the colour pipeline; zero in blanking. frame_start is
  // gated by rst so it stays low while the counters are held at the origin.
  always_comb begin
    x           = visible ? h_cnt : '0;
    y           = visible ? v_cnt[8:0] : '0;
    frame_start = !rst && (h_cnt == '0) && (v_cnt == '0);
  end

  // Two-stage sync/blank delay plus the colour output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      vis_d1 <= 1'b0;
      hs     <= 1'b1;
      vs     <= 1'b1;
      r      <= '0;
      g      <= '0;
      b      <= '0;
    end else begin
      hs_d1  <= hs_raw;
      vs_d1  <= vs_raw;
      vis_d1 <= visible;
      hs     <= hs_d1;
      vs     <= vs_d1;
      if (vis_d1) begin
        r <= color_in[15:12];
        g <= color_in[10:7];
        b <= color_in[4:1];
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using a reduced timing set
// (16 clocks per line, 11 lines per frame) so full frames fit in a short run.
module tb_vga_scan_ctrl;

  localparam int HV = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VV = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HV + HFP + HS + HBP;  // 16
  localparam int VT = VV + VFP + VS + VBP;  // 11
  localparam int FT = HT * VT;              // 176

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] color_in = 16'h0000;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        hs, vs;
  logic [3:0]  r, g, b;
  logic        frame_start;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int hs_run = 0;
  int vs_run = 0;
  int last_fs = -1;

  vga_scan_ctrl #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .color_in(color_in),
    .x(x), .y(y), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic bit mvis(input int tt);
    return ((tt % HT) < HV) && (((tt / HT) % VT) < VV);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_h_cnt"}, 32'(dut.h_cnt), 0);
    chk({tag, "_v_cnt"}, 32'(dut.v_cnt), 0);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_rgb"}, {20'h0, r, g, b}, 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  // Compare every output against the cycle-count model at time index t.
  task automatic check_all();
    int hp, vp, ph, pv;
    logic ehs, evs;
    logic [11:0] ergb;
    hp = t % HT;
    vp = (t / HT) % VT;
    chk("h_cnt", 32'(dut.h_cnt), hp);
    chk("v_cnt", 32'(dut.v_cnt), vp);
    chk("x", 32'(x), mvis(t) ? hp : 0);
    chk("y", 32'(y), mvis(t) ? vp : 0);
    chk("frame_start", 32'(frame_start), (t % FT) == 0 ? 1 : 0);
    ehs  = 1'b1;
    evs  = 1'b1;
    ergb = 12'h000;
    if (t >= 2) begin
      ph  = (t - 2) % HT;
      pv  = ((t - 2) / HT) % VT;
      ehs = !(ph >= HV + HFP && ph < HV + HFP + HS);
      evs = !(pv >= VV + VFP && pv < VV + VFP + VS);
      if (mvis(t - 2)) ergb = (ph == 0 && pv == 0) ? 12'hF00 : 12'h00F;
    end
    chk("hs", 32'(hs), 32'(ehs));
    chk("vs", 32'(vs), 32'(evs));
    chk("rgb", {20'h0, r, g, b}, {20'h0, ergb});
    if (!hs) hs_run++;
    else if (hs_run > 0) begin
      chk("hs_low_width", hs_run, HS);
      hs_run = 0;
    end
    if (!vs) vs_run++;
    else if (vs_run > 0) begin
      chk("vs_low_width", vs_run, VS * HT);
      vs_run = 0;
    end
    if (frame_start) begin
      if (last_fs >= 0) chk("fs_period", t - last_fs, FT);
      last_fs = t;
    end
  endtask

  // Advance one clock; the colour source returns f(x,y) one clock after x/y.
  task automatic step();
    logic [15:0] nc;
    nc = !mvis(t) ? 16'hFFFF : ((x == 10'd0 && y == 9'd0) ? 16'hF800 : 16'h001F);
    @(posedge clk);
    #1;
    color_in = nc;
    t++;
    check_all();
  endtask

  initial begin
    // Held in reset across several edges.
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    #1;
    check_all();
    // Two full frames plus a partial one, stopping at h=12, v=3 where hs is low.
    for (int i = 0; i < 2 * FT + 3 * HT + 12; i++) step();
    chk("pre_rst_hs_low", 32'(hs), 0);

    // Mid-frame async reset, no clock edge in between.
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("rst_held");
    hs_run = 0;
    vs_run = 0;
    last_fs = -1;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    #1;
    check_all();
    for (int i = 0; i < FT + 20; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
